// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions used by the fetch stage and the IF/ID register:
// reset PC, bubble instruction encoding and the fetch FSM state type.
package fetch_unit_pkg;

  localparam logic [31:0] CPU_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] CPU_NOP_INSN = 32'h0000_0000;

  // FETCH: request outstanding at pc
  // HOLD : instruction parked in ibuf while IF/ID is stalled, no request
  // DRAIN: waiting out a request that a redirect made stale
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // Instruction addresses are word aligned; low two bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register. Owns the PC, drives a
// req/ack instruction memory, parks one instruction while IF/ID stalls and
// lets stale requests complete after a redirect before fetching the target.
//
// Memory handshake: imem_req is a request that, once raised, holds imem_req
// and imem_addr stable until the cycle in which imem_ack is high; that cycle
// (which may be the first request cycle) completes the transfer and
// imem_rdata is valid only then. A request is never withdrawn except by reset.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = CPU_RESET_PC,
  parameter logic [31:0] NOP_INSN = CPU_NOP_INSN
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  ins_out,
  output logic [31:0]  pc_out,
  output logic         ins_valid,
  output fetch_state_e fsm_state
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  logic [31:0]  ibuf_q, ibuf_d;

  logic [31:0]  pc_inc;
  logic [31:0]  redirect_tgt;

  assign pc_inc       = pc_q + 32'd4;
  assign redirect_tgt = align_word(redirect_pc);
  assign fsm_state    = state_q;

  // State and datapath registers, asynchronously reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= 32'd0;
      ibuf_q       <= NOP_INSN;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      ibuf_q       <= ibuf_d;
    end
  end

  // Next-state and register updates; redirect beats stall beats advance.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    ibuf_d       = ibuf_q;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_d = redirect_tgt;
          // An unfinished request must still complete; remember its address.
          if (!imem_ack) begin
            drain_addr_d = pc_q;
            state_d      = DRAIN;
          end
        end else if (imem_ack) begin
          if (stall) begin
            ibuf_d  = imem_rdata;
            state_d = HOLD;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = redirect_tgt;
          state_d = FETCH;
        end else if (!stall) begin
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        // A newer redirect just retargets; the stale request still finishes.
        if (redirect) begin
          pc_d = redirect_tgt;
        end
        if (imem_ack) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Output decode; reset forces the idle/bubble values immediately.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    pc_out    = pc_q;
    ins_valid = 1'b0;
    ins_out   = NOP_INSN;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          imem_req  = 1'b1;
          imem_addr = pc_q;
          ins_valid = imem_ack & ~redirect;
          ins_out   = imem_ack ? imem_rdata : NOP_INSN;
        end
        HOLD: begin
          ins_valid = ~redirect;
          ins_out   = ibuf_q;
        end
        DRAIN: begin
          imem_req  = 1'b1;
          imem_addr = drain_addr_q;
        end
        default: begin
          imem_req = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized run
// against a program-order model of the accepted instruction stream.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         stall;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ack;
  logic [31:0]  imem_rdata;
  logic [31:0]  ins_out;
  logic [31:0]  pc_out;
  logic         ins_valid;
  fetch_state_e fsm_state;

  int checks   = 0;
  int failures = 0;

  // Randomized-phase model state
  logic [31:0] exp_pc;
  int          accepted;
  logic        mem_busy;
  int          mem_lat;
  logic        prev_req;
  logic        prev_ack;
  logic [31:0] prev_addr;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ins_out     (ins_out),
    .pc_out      (pc_out),
    .ins_valid   (ins_valid),
    .fsm_state   (fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] mw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then let outputs settle.
  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic ack);
    @(negedge clk);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ack    = ack;
    imem_rdata  = ack ? mw(imem_addr) : 32'hDEAD_BEEF;
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(imem_req),  32'd0);
    chk({tag, "_valid"}, 32'(ins_valid), 32'd0);
    chk({tag, "_ins"},   ins_out,        32'h0000_0000);
    chk({tag, "_pc"},    pc_out,         32'h8000_0000);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    imem_ack = 1'b0; imem_rdata = 32'd0;
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("release_req",  32'(imem_req), 32'd1);
    chk("release_addr", imem_addr,      32'h8000_0000);

    // Zero-wait memory, no stall
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("zw0_addr",  imem_addr,       32'h8000_0000);
    chk("zw0_valid", 32'(ins_valid),  32'd1);
    chk("zw0_ins",   ins_out,         mw(32'h8000_0000));
    chk("zw0_pc",    pc_out,          32'h8000_0000);

    // Ack for 0x80000004 with stall -> held for 3 cycles
    drive(1'b1, 1'b0, 32'd0, 1'b1);
    chk("zw1_addr",  imem_addr,       32'h8000_0004);
    chk("zw1_valid", 32'(ins_valid),  32'd1);
    chk("zw1_ins",   ins_out,         mw(32'h8000_0004));
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'd0, 1'b0);
      chk("hold_req",   32'(imem_req),  32'd0);
      chk("hold_pc",    pc_out,         32'h8000_0004);
      chk("hold_ins",   ins_out,        mw(32'h8000_0004));
      chk("hold_valid", 32'(ins_valid), 32'd1);
      chk("hold_state", 32'(fsm_state), 32'(HOLD));
    end
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    chk("unstall_valid", 32'(ins_valid), 32'd1);
    chk("unstall_pc",    pc_out,         32'h8000_0004);
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    chk("zw2_req",   32'(imem_req),  32'd1);
    chk("zw2_addr",  imem_addr,      32'h8000_0008);
    chk("zw2_valid", 32'(ins_valid), 32'd0);
    chk("zw2_ins",   ins_out,        32'h0000_0000);

    // Reset in the middle of a wait: outputs change without a clock edge
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel2_req",   32'(imem_req),  32'd1);
    chk("rel2_addr",  imem_addr,      32'h8000_0000);
    chk("rel2_valid", 32'(ins_valid), 32'd0);

    // 3-cycle latency, redirect in the second wait cycle
    drive(1'b0, 1'b1, 32'h8000_0103, 1'b0);
    chk("lat_w2_addr",  imem_addr,      32'h8000_0000);
    chk("lat_w2_valid", 32'(ins_valid), 32'd0);
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    chk("lat_w3_req",   32'(imem_req),  32'd1);
    chk("lat_w3_addr",  imem_addr,      32'h8000_0000);
    chk("lat_w3_valid", 32'(ins_valid), 32'd0);
    chk("lat_w3_pc",    pc_out,         32'h8000_0100);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("lat_ack_addr",  imem_addr,      32'h8000_0000);
    chk("lat_ack_valid", 32'(ins_valid), 32'd0);
    chk("lat_ack_ins",   ins_out,        32'h0000_0000);
    drive(1'b1, 1'b0, 32'd0, 1'b1);
    chk("tgt_addr",  imem_addr,      32'h8000_0100);
    chk("tgt_valid", 32'(ins_valid), 32'd1);
    chk("tgt_ins",   ins_out,        mw(32'h8000_0100));

    // Redirect while holding: buffered instruction is dropped
    drive(1'b1, 1'b1, 32'h8000_0200, 1'b0);
    chk("hold_rd_valid", 32'(ins_valid), 32'd0);
    chk("hold_rd_req",   32'(imem_req),  32'd0);
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    chk("hold_rd_next_req",   32'(imem_req),  32'd1);
    chk("hold_rd_next_addr",  imem_addr,      32'h8000_0200);
    chk("hold_rd_next_valid", 32'(ins_valid), 32'd0);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("hold_rd_ack_valid", 32'(ins_valid), 32'd1);
    chk("hold_rd_ack_ins",   ins_out,        mw(32'h8000_0200));
    chk("hold_rd_ack_pc",    pc_out,         32'h8000_0200);

    // Redirect coinciding with ack, then PC wrap-around
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    chk("rd_ack_addr",  imem_addr,      32'h8000_0204);
    chk("rd_ack_valid", 32'(ins_valid), 32'd0);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("wrap_hi_addr",  imem_addr,      32'hFFFF_FFFC);
    chk("wrap_hi_valid", 32'(ins_valid), 32'd1);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("wrap_lo_addr", imem_addr,      32'h0000_0000);
    chk("wrap_lo_pc",   pc_out,         32'h0000_0000);
    chk("wrap_lo_ins",  ins_out,        mw(32'h0000_0000));

    // Randomized run: accepted instructions must follow program order
    @(negedge clk);
    reset = 1'b1; imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0;
    exp_pc = 32'h8000_0000; accepted = 0;
    mem_busy = 1'b0; mem_lat = 0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'd0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      reset = 1'b0;
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1; imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0;
        #1;
        chk_reset_outputs("rnd_reset");
        exp_pc = 32'h8000_0000;
        mem_busy = 1'b0; prev_req = 1'b0; prev_ack = 1'b0;
      end else begin
        stall       = ($urandom_range(0, 3) == 0);
        redirect    = ($urandom_range(0, 11) == 0);
        redirect_pc = $urandom;
        if (imem_req) begin
          if (!mem_busy) begin
            mem_busy = 1'b1;
            mem_lat  = $urandom_range(0, 3);
          end
          if (mem_lat == 0) begin
            imem_ack = 1'b1;
            mem_busy = 1'b0;
          end else begin
            imem_ack = 1'b0;
            mem_lat--;
          end
        end else begin
          imem_ack = 1'b0;
        end
        imem_rdata = imem_ack ? mw(imem_addr) : $urandom;
        #1;
        if (prev_req && !prev_ack) begin
          chk("rnd_req_held",  32'(imem_req), 32'd1);
          chk("rnd_addr_held", imem_addr,     prev_addr);
        end
        if (imem_req) chk("rnd_addr_align", 32'(imem_addr[1:0]), 32'd0);
        if (redirect) chk("rnd_rd_valid", 32'(ins_valid), 32'd0);
        if (ins_valid) chk("rnd_ins_data", ins_out, mw(pc_out));
        if (ins_valid && !stall) begin
          chk("rnd_order_pc", pc_out, exp_pc);
          exp_pc = exp_pc + 32'd4;
          accepted++;
        end
        if (redirect) exp_pc = redirect_pc & 32'hFFFF_FFFC;
        prev_req  = imem_req;
        prev_ack  = imem_ack;
        prev_addr = imem_addr;
      end
    end
    chk("rnd_progress", 32'(accepted > 100), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the program counter and issues requests on a req/ack instruction-memory port. Each returned word goes to IF/ID together with its PC. It absorbs hazard-unit stalls with a one-entry hold buffer, and it handles branch/jump redirects, including redirects that arrive while a memory access is still outstanding.

## Interface
- `RESET_PC`, default `32'h8000_0000`: PC loaded on reset; matches IF/ID reset PC.
- `NOP_INSN`, default `32'h0000_0000`: value driven on `ins_out` when no valid instruction.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `stall`  in  1  IF/ID not accepting this cycle (inverse of `wr_IF2ID`).
- `redirect`  in  1  taken branch/jump/exception; same cycle as `flush_IF2ID`.
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored and forced to 0.
- `imem_req`  out  1  memory request.
- `imem_addr`  out  32  word-aligned request address.
- `imem_ack`  in  1  response valid; may arrive in the request cycle (zero-wait) or later.
- `imem_rdata`  in  32  instruction; valid only when `imem_ack`=1.
- `ins_out`  out  32  to IF/ID `ins_in`.
- `pc_out`  out  32  to IF/ID `pc_in`.
- `ins_valid`  out  1  `ins_out` holds a real instruction; the hazard unit ORs `!ins_valid` into the bubble/flush logic.

## Operation
- Internal state:
  - `pc` (32b), `drain_addr` (32b), `ibuf` (32b).
  - State machine with states FETCH, HOLD, DRAIN.
- Memory rule: once `imem_req` rises, `imem_req` and `imem_addr` stay stable until `imem_ack`. A request is never abandoned.
- FETCH:
  - Outputs: `imem_req`=1, `imem_addr`=`pc`, `pc_out`=`pc`, `ins_valid`=`imem_ack & !redirect`, `ins_out`=`imem_ack ? imem_rdata : NOP_INSN`.
  - `redirect` & `imem_ack`: `pc`<=`redirect_pc`; stay FETCH; response dropped.
  - `redirect` & `!imem_ack`: `drain_addr`<=`pc`, `pc`<=`redirect_pc`; go to DRAIN.
  - `imem_ack` & `!stall`: `pc`<=`pc+4`; stay FETCH. This gives one instruction per cycle with zero-wait memory.
  - `imem_ack` & `stall`: `ibuf`<=`imem_rdata`; go to HOLD.
  - Otherwise: stay FETCH.
- HOLD:
  - Outputs: `imem_req`=0, `ins_valid`=`!redirect`, `ins_out`=`ibuf`, `pc_out`=`pc`.
  - `redirect`: `pc`<=`redirect_pc`; go to FETCH.
  - `!stall`: `pc`<=`pc+4`; go to FETCH.
  - Otherwise: stay HOLD.
- DRAIN:
  - Outputs: `imem_req`=1, `imem_addr`=`drain_addr`, `ins_valid`=0, `ins_out`=`NOP_INSN`, `pc_out`=`pc`.
  - `imem_ack`: response discarded; go to FETCH.
  - A further `redirect` in DRAIN updates `pc` and stays in DRAIN.
- Priority: `redirect` > `stall` > normal advance.
- Arithmetic: `pc+4` is modulo 2^32, so `32'hFFFF_FFFC` wraps to `32'h0000_0000`.

## Timing
- Reset (asynchronous, takes effect immediately):
  - Registers: `pc`=`RESET_PC`, state=FETCH, `ibuf`=`NOP_INSN`, `drain_addr`=0.
  - Outputs while reset is high: `imem_req`=0, `ins_valid`=0, `ins_out`=`NOP_INSN`, `pc_out`=`RESET_PC`.
- First edge after reset release: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Latency: instruction appears on `ins_out` in the `imem_ack` cycle. IF/ID captures it at the end of that cycle.
- Stall entered in an ack cycle:
  - The instruction re-appears from `ibuf` every cycle until `stall` drops.
  - No new request is issued while in HOLD.
- Reset mid-DRAIN or mid-request: the FSM returns to FETCH with `imem_req`=0. The memory model must tolerate the dropped request; the system-level reset also resets memory.
- `redirect` and `stall` in the same cycle: the redirect wins and `ins_valid`=0.

## Structure
- Shared CPU package contents:
  - `RESET_PC` and `NOP_INSN` constants, reused by IF/ID.
  - The fetch state enum: FETCH, HOLD, DRAIN.
- Single flat module, no sub-modules. The PC adder and the output mux stay inline.

## Test plan
- Zero-wait memory (ack in every request cycle), `stall`=0: addresses 0x80000000, 0x80000004, 0x80000008 on consecutive cycles, with `ins_valid`=1 each cycle.
- Ack for 0x80000004 while `stall`=1 for 3 cycles: HOLD; `ins_out` is held, `imem_req`=0 and `pc_out`=0x80000004 for those 3 cycles. Next request is 0x80000008.
- 3-cycle memory latency; `redirect`=1 with `redirect_pc`=0x80000103 in the 2nd wait cycle:
  - `imem_addr` stays 0x80000000 until ack, with `ins_valid`=0.
  - The following request is 0x80000100.
- `redirect` in HOLD: next cycle is FETCH with `imem_addr`=`redirect_pc`; the buffered instruction is never marked valid again.
- `pc`=0xFFFFFFFC, ack, `stall`=0 → next `imem_addr`=0x00000000.
- Assert `reset` mid-wait: outputs immediately take their reset values. After release, the first request is 0x80000000.
